// File: rtl/rsa_pkg.sv
// Shared RSA primitive definitions: default operand width, octet count,
// the 9-bit octet-length type and the I2OSP controller state encoding.
package rsa_pkg;

    localparam int DEF_DATA_BIT_WIDTH = 2048;
    localparam int NOCT               = DEF_DATA_BIT_WIDTH / 8;

    typedef logic [8:0] len_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/i2osp_stream_if.sv
// Request, octet-stream and result signals of the I2OSP streaming encoder.
interface i2osp_stream_if
    import rsa_pkg::*;
#(
    parameter int DATA_BIT_WIDTH = DEF_DATA_BIT_WIDTH
) ();

    // Handshakes: a request moves when i_valid && o_ready on a rising edge;
    // an octet moves when o_oct_valid && i_oct_ready. o_oct_valid never waits on
    // i_oct_ready, and o_oct stays stable while o_oct_valid is high without a transfer.
    logic                      i_valid;
    logic [DATA_BIT_WIDTH-1:0] i_x;
    len_t                      i_xlen;
    logic                      o_ready;
    logic [7:0]                o_oct;
    logic                      o_oct_valid;
    logic                      o_oct_last;
    logic                      i_oct_ready;
    logic [DATA_BIT_WIDTH-1:0] o_X;
    logic                      o_valid;
    logic                      o_err;

    modport master (
        output i_valid, i_x, i_xlen, i_oct_ready,
        input  o_ready, o_oct, o_oct_valid, o_oct_last, o_X, o_valid, o_err
    );

    modport slave (
        input  i_valid, i_x, i_xlen, i_oct_ready,
        output o_ready, o_oct, o_oct_valid, o_oct_last, o_X, o_valid, o_err
    );

endinterface

// File: rtl/i2osp_stream.sv
// I2OSP encoder: checks that x fits in xLen octets (scanning high octets first),
// then streams the xLen octets MSB-first while building a left-justified copy.
module i2osp_stream
    import rsa_pkg::*;
#(
    parameter int DATA_BIT_WIDTH = DEF_DATA_BIT_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    i2osp_stream_if.slave  bus,
    output state_t         dbg_state
);

    localparam int   OCTS     = DATA_BIT_WIDTH / 8;
    localparam len_t OCTS_LEN = len_t'(OCTS);
    localparam len_t IDX_TOP  = len_t'(OCTS - 1);

    state_t                    state, state_n;
    logic [DATA_BIT_WIDTH-1:0] x_q;
    logic [DATA_BIT_WIDTH-1:0] x_out_q;
    len_t                      xlen_q;
    len_t                      idx;
    logic                      err_q;

    logic [7:0] cur_oct;
    logic       bad_len;
    len_t       out_pos;

    always_comb begin
        cur_oct = 8'(x_q >> {idx, 3'b000});
        bad_len = (bus.i_xlen == '0) || (bus.i_xlen > OCTS_LEN);
        // Position of the current octet counted from the left of o_X.
        out_pos = xlen_q - 9'd1 - idx;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n          = state;
        bus.o_ready      = 1'b0;
        bus.o_oct_valid  = 1'b0;
        bus.o_oct        = '0;
        bus.o_oct_last   = 1'b0;
        bus.o_valid      = 1'b0;
        unique case (state)
            IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_valid) begin
                    if (bad_len)                     state_n = DONE;
                    else if (bus.i_xlen == OCTS_LEN) state_n = EMIT;
                    else                             state_n = SCAN;
                end
            end
            SCAN: begin
                if (cur_oct != 8'd0)    state_n = DONE;
                else if (idx == xlen_q) state_n = EMIT;
            end
            EMIT: begin
                bus.o_oct_valid = 1'b1;
                bus.o_oct       = cur_oct;
                bus.o_oct_last  = (idx == '0);
                if (bus.i_oct_ready && idx == '0) state_n = DONE;
            end
            DONE: begin
                bus.o_valid = 1'b1;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= '0;
            x_out_q <= '0;
            xlen_q  <= '0;
            idx     <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        x_q     <= bus.i_x;
                        xlen_q  <= bus.i_xlen;
                        x_out_q <= '0;
                        idx     <= IDX_TOP;
                        err_q   <= bad_len;
                    end
                end
                SCAN: begin
                    // Leaving SCAN at idx == xLen lands idx on xLen-1 for EMIT.
                    if (cur_oct != 8'd0) err_q <= 1'b1;
                    else                 idx   <= idx - 9'd1;
                end
                EMIT: begin
                    if (bus.i_oct_ready) begin
                        x_out_q <= x_out_q |
                                   ({cur_oct, {(DATA_BIT_WIDTH-8){1'b0}}} >> {out_pos, 3'b000});
                        if (idx != '0) idx <= idx - 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_X   = x_out_q;
    assign bus.o_err = err_q;
    assign dbg_state = state;

endmodule
